// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port MIPS register file.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_RD   = 2;
    localparam int RF_ZERO_REG = 1;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of regfile_mp: two write ports, packed read ports and the clear handshake.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 5
) ();

    logic                           we_0;
    logic [ADDR_W-1:0]              waddr_0;
    logic [DATA_W-1:0]              wdata_0;
    logic                           we_1;
    logic [ADDR_W-1:0]              waddr_1;
    logic [DATA_W-1:0]              wdata_1;
    logic [NUM_RD-1:0][ADDR_W-1:0]  raddr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rdata;
    logic                           clr_req;
    logic                           clr_busy;
    logic                           clr_done;

    modport master (
        output we_0, waddr_0, wdata_0,
        output we_1, waddr_1, wdata_1,
        output raddr, clr_req,
        input  rdata, clr_busy, clr_done
    );

    modport slave (
        input  we_0, waddr_0, wdata_0,
        input  we_1, waddr_1, wdata_1,
        input  raddr, clr_req,
        output rdata, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clr_seq.sv
// Sweep-clear sequencer: walks every writable register once, one per cycle, then pulses done.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_s,
    input  logic              clr_req,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_REG != 32'sd0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state_r, state_s;
    logic [ADDR_W-1:0] idx_r, idx_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Next-state logic; busy/done are precomputed so they leave the block as flops.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_s = CLR_CLEAR;
                    idx_s   = FIRST_IDX;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            CLR_CLEAR: begin
                if (idx_r == LAST_IDX) begin
                    state_s = CLR_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    idx_s   = idx_r + ADDR_W'(1);
                    busy_s  = 1'b1;
                end
            end
            CLR_DONE: begin
                state_s = CLR_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = CLR_IDLE;
                idx_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state_r <= CLR_IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign sweep_we   = (state_r == CLR_CLEAR);
    assign sweep_addr = idx_r;
    assign clr_busy   = busy_r;
    assign clr_done   = done_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD async reads, two prioritised writes, sweep clear.
// Optional same-cycle write forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic         clk,
    input  logic         rst_s,
    regfile_mp_if.slave  bus
);

    logic [DATA_W-1:0]             mem_r [NUM_REGS];
    logic                          sweep_we_s;
    logic [ADDR_W-1:0]             sweep_addr_s;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0]             rd_s;
    logic                          hit_s;
`ifdef REGFILE_BYPASS_EN
    logic                          addr_ok_s;
`endif

    function automatic logic reg_writable(input int r);
        return !((ZERO_REG != 32'sd0) && (r == 32'sd0));
    endfunction

    regfile_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clr_seq (
        .clk        (clk),
        .rst_s      (rst_s),
        .clr_req    (bus.clr_req),
        .sweep_we   (sweep_we_s),
        .sweep_addr (sweep_addr_s),
        .clr_busy   (bus.clr_busy),
        .clr_done   (bus.clr_done)
    );

    // Storage update: port 1 beats port 0, both beat the sweep; out-of-range writes match no entry.
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_writable(r) && bus.we_1 && (bus.waddr_1 == ADDR_W'(r))) begin
                    mem_r[r] <= bus.wdata_1;
                end else if (reg_writable(r) && bus.we_0 && (bus.waddr_0 == ADDR_W'(r))) begin
                    mem_r[r] <= bus.wdata_0;
                end else if (sweep_we_s && (sweep_addr_s == ADDR_W'(r))) begin
                    mem_r[r] <= '0;
                end else begin
                    mem_r[r] <= mem_r[r];
                end
            end
        end
    end

    // AND-OR read mux; unreadable or out-of-range addresses select nothing and read zero.
    always_comb begin
        rdata_s = '0;
        rd_s    = '0;
        hit_s   = 1'b0;
`ifdef REGFILE_BYPASS_EN
        addr_ok_s = 1'b0;
`endif
        for (int i = 0; i < NUM_RD; i++) begin
            rd_s = '0;
`ifdef REGFILE_BYPASS_EN
            addr_ok_s = 1'b0;
`endif
            for (int r = 0; r < NUM_REGS; r++) begin
                hit_s = reg_writable(r) && (bus.raddr[i] == ADDR_W'(r));
                rd_s  = rd_s | (mem_r[r] & {DATA_W{hit_s}});
`ifdef REGFILE_BYPASS_EN
                addr_ok_s = addr_ok_s | hit_s;
`endif
            end
`ifdef REGFILE_BYPASS_EN
            if (addr_ok_s && bus.we_1 && (bus.waddr_1 == bus.raddr[i])) begin
                rd_s = bus.wdata_1;
            end else if (addr_ok_s && bus.we_0 && (bus.waddr_0 == bus.raddr[i])) begin
                rd_s = bus.wdata_0;
            end else if (addr_ok_s && sweep_we_s && (sweep_addr_s == bus.raddr[i])) begin
                rd_s = '0;
            end else begin
                rd_s = rd_s;
            end
`endif
            rdata_s[i] = rd_s;
        end
    end

    assign bus.rdata = rdata_s;

endmodule
